// File: rtl/lzrw1_decompressor_top.sv
// Streaming LZRW1 decompressor: literal and copy items in, one byte per cycle out, circular history.
// Optional LZRW1_DECOMP_CHECK_EN adds a sticky copy_error flag for invalid copy offsets.
module lzrw1_decompressor_top #(
    parameter int HISTORY_SIZE = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        control_word_in,
    input  logic        data_in_valid,
    output logic [7:0]  decompressed_byte,
    output logic        out_valid,
    output logic        decompressor_busy
`ifdef LZRW1_DECOMP_CHECK_EN
    ,
    output logic        copy_error
`endif
);

    localparam int PW = $clog2(HISTORY_SIZE);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LIT_DONE  = 2'd1,
        COPY      = 2'd2,
        COPY_DONE = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [PW-1:0] wr_ptr_r, src_r, src_s;
    logic [4:0]    remaining_r, remaining_s;
    logic [7:0]    byte_s;
    logic          valid_s, busy_s;
    logic          wr_en_s;
    logic [7:0]    wr_data_s;
    logic [7:0]    hist_r [HISTORY_SIZE];
    logic [11:0]   off_s;
    logic [4:0]    len_s;
    logic [7:0]    hist_rd_s;

    assign off_s     = {data_in[15:12], data_in[7:0]};
    assign len_s     = {1'b0, data_in[11:8]} + 5'd3;
    // Asynchronous read lets an overlapping copy see the byte written on the previous edge.
    assign hist_rd_s = hist_r[src_r];

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        src_s       = src_r;
        remaining_s = remaining_r;
        byte_s      = decompressed_byte;
        valid_s     = 1'b0;
        busy_s      = decompressor_busy;
        wr_en_s     = 1'b0;
        wr_data_s   = 8'h00;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (data_in_valid) begin
                    busy_s = 1'b1;
                    if (control_word_in) begin
                        src_s       = wr_ptr_r - off_s[PW-1:0];
                        remaining_s = len_s;
                        state_s     = COPY;
                    end else begin
                        byte_s    = data_in[7:0];
                        valid_s   = 1'b1;
                        wr_en_s   = 1'b1;
                        wr_data_s = data_in[7:0];
                        state_s   = LIT_DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LIT_DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            COPY: begin
                byte_s      = hist_rd_s;
                valid_s     = 1'b1;
                busy_s      = 1'b1;
                wr_en_s     = 1'b1;
                wr_data_s   = hist_rd_s;
                src_s       = src_r + PTR_ONE;
                remaining_s = remaining_r - 5'd1;
                if (remaining_r == 5'd1) begin
                    state_s = COPY_DONE;
                end else begin
                    state_s = COPY;
                end
            end
            COPY_DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r           <= IDLE;
            wr_ptr_r          <= '0;
            src_r             <= '0;
            remaining_r       <= 5'd0;
            decompressed_byte <= 8'h00;
            out_valid         <= 1'b0;
            decompressor_busy <= 1'b0;
        end else begin
            state_r           <= state_s;
            wr_ptr_r          <= wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            src_r             <= src_s;
            remaining_r       <= remaining_s;
            decompressed_byte <= byte_s;
            out_valid         <= valid_s;
            decompressor_busy <= busy_s;
        end
    end

    // History array; every emitted byte lands at wr_ptr.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HISTORY_SIZE; i++) begin
                hist_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            hist_r[wr_ptr_r] <= wr_data_s;
        end
    end

`ifdef LZRW1_DECOMP_CHECK_EN
    localparam int EW = PW + 1;
    localparam logic [EW-1:0] EMIT_MAX = EW'(HISTORY_SIZE);

    logic [EW-1:0] emitted_r;
    logic          err_r;
    logic          accept_copy_s;
    logic          bad_off_s;

    assign accept_copy_s = (state_r == IDLE) && data_in_valid && control_word_in;
    assign bad_off_s     = (off_s == 12'd0)
                        || ({1'b0, off_s} >= 13'(HISTORY_SIZE))
                        || ({1'b0, off_s} > 13'(emitted_r));
    assign copy_error    = err_r;

    // Saturating emitted-byte count and sticky offset error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            emitted_r <= '0;
            err_r     <= 1'b0;
        end else begin
            if (wr_en_s && (emitted_r != EMIT_MAX)) begin
                emitted_r <= emitted_r + EW'(1);
            end
            if (accept_copy_s && bad_off_s) begin
                err_r <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lzrw1_decompressor_top.sv
// Scoreboard bench for lzrw1_decompressor_top (HISTORY_SIZE=256); copy_error checks under LZRW1_DECOMP_CHECK_EN.
module tb_lzrw1_decompressor_top;

    logic        clock;
    logic        reset;
    logic [15:0] data_in;
    logic        control_word_in;
    logic        data_in_valid;
    logic [7:0]  decompressed_byte;
    logic        out_valid;
    logic        decompressor_busy;
`ifdef LZRW1_DECOMP_CHECK_EN
    logic        copy_error;
`endif

    int tests_run = 0;
    int failed    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] seen[$];
    logic [7:0] mhist [256];
    logic [7:0] mptr;

    lzrw1_decompressor_top #(.HISTORY_SIZE(256)) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .control_word_in   (control_word_in),
        .data_in_valid     (data_in_valid),
        .decompressed_byte (decompressed_byte),
        .out_valid         (out_valid),
        .decompressor_busy (decompressor_busy)
`ifdef LZRW1_DECOMP_CHECK_EN
        ,
        .copy_error        (copy_error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output monitor: every valid byte is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            seen.push_back(decompressed_byte);
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL scoreboard_underflow got=%h expected=none", decompressed_byte);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (decompressed_byte !== e) begin
                    failed++;
                    $display("FAIL scoreboard_byte got=%h expected=%h", decompressed_byte, e);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mhist[i] = 8'h00;
        mptr = 8'h00;
        exp_q.delete();
        seen.delete();
    endtask

    task automatic model_push(input logic cw, input logic [15:0] d);
        logic [11:0] off;
        int          len;
        logic [7:0]  src;
        logic [7:0]  b;
        if (!cw) begin
            exp_q.push_back(d[7:0]);
            mhist[mptr] = d[7:0];
            mptr++;
        end else begin
            off = {d[15:12], d[7:0]};
            len = int'(d[11:8]) + 3;
            src = mptr - off[7:0];
            for (int i = 0; i < len; i++) begin
                b = mhist[src];
                exp_q.push_back(b);
                mhist[mptr] = b;
                src++;
                mptr++;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        data_in_valid = 1'b0;
        data_in = 16'h0000;
        control_word_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Presents one item, then counts busy and out_valid cycles until busy falls.
    task automatic send_item(input logic cw, input logic [15:0] d, output int nv, output int nb);
        int t;
        t = 0;
        @(negedge clock);
        while (decompressor_busy !== 1'b0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            tests_run++;
            failed++;
            $display("FAIL busy_timeout busy=%b expected=0", decompressor_busy);
        end
        control_word_in = cw;
        data_in = d;
        data_in_valid = 1'b1;
        model_push(cw, d);
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        nv = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) nv++;
            if (decompressor_busy === 1'b1) nb++;
            else break;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        int nv, nb;
        apply_reset();
        send_item(1'b0, 16'h005A, nv, nb);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || decompressor_busy !== 1'b0 || decompressed_byte !== 8'h00) begin
            failed++;
            $display("FAIL reset_state got v=%b b=%b d=%h expected v=0 b=0 d=00",
                     out_valid, decompressor_busy, decompressed_byte);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || decompressor_busy !== 1'b0) begin
                failed++;
                $display("FAIL idle_no_valid got v=%b b=%b expected v=0 b=0", out_valid, decompressor_busy);
            end
        end
    endtask

    task automatic test_literals();
        logic [7:0] lit [3];
        lit[0] = 8'h61; lit[1] = 8'h62; lit[2] = 8'h63;
        apply_reset();
        @(negedge clock);
        control_word_in = 1'b0;
        data_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = {8'h00, lit[k]};
            model_push(1'b0, data_in);
            @(posedge clock);
            #1;
            tests_run++;
            if (decompressor_busy !== 1'b1 || out_valid !== 1'b1) begin
                failed++;
                $display("FAIL lit_accept k=%0d got b=%b v=%b expected b=1 v=1", k, decompressor_busy, out_valid);
            end
            @(posedge clock);
            #1;
            tests_run++;
            if (decompressor_busy !== 1'b0 || out_valid !== 1'b0) begin
                failed++;
                $display("FAIL lit_done k=%0d got b=%b v=%b expected b=0 v=0", k, decompressor_busy, out_valid);
            end
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        tests_run++;
        if (seen.size() != 3 || seen[0] !== 8'h61 || seen[1] !== 8'h62 || seen[2] !== 8'h63) begin
            failed++;
            $display("FAIL lit_stream got size=%0d expected 616263", seen.size());
        end
    endtask

    task automatic test_copy();
        int nv, nb;
        logic [7:0] want [6];
        want[0] = 8'h61; want[1] = 8'h62; want[2] = 8'h63;
        want[3] = 8'h61; want[4] = 8'h62; want[5] = 8'h63;
        apply_reset();
        send_item(1'b0, 16'h0061, nv, nb);
        send_item(1'b0, 16'h0062, nv, nb);
        send_item(1'b0, 16'h0063, nv, nb);
        send_item(1'b1, 16'h0003, nv, nb);
        tests_run++;
        if (nv != 3 || nb != 4) begin
            failed++;
            $display("FAIL copy_timing got valid=%0d busy=%0d expected valid=3 busy=4", nv, nb);
        end
        tests_run++;
        if (seen.size() != 6) begin
            failed++;
            $display("FAIL copy_len got=%0d expected=6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (seen[i] !== want[i]) begin
                    failed++;
                    $display("FAIL copy_byte i=%0d got=%h expected=%h", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_overlap();
        int nv, nb;
        apply_reset();
        send_item(1'b0, 16'h0061, nv, nb);
        send_item(1'b0, 16'h0062, nv, nb);
        send_item(1'b1, 16'h0201, nv, nb);
        tests_run++;
        if (nv != 5 || nb != 6) begin
            failed++;
            $display("FAIL overlap_timing got valid=%0d busy=%0d expected valid=5 busy=6", nv, nb);
        end
        tests_run++;
        if (seen.size() != 7 || seen[0] !== 8'h61) begin
            failed++;
            $display("FAIL overlap_len got=%0d expected=7", seen.size());
        end else begin
            for (int i = 1; i < 7; i++) begin
                if (seen[i] !== 8'h62) begin
                    failed++;
                    $display("FAIL overlap_byte i=%0d got=%h expected=62", i, seen[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int nv, nb;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            send_item(1'b0, 16'(i % 251), nv, nb);
        end
        send_item(1'b1, 16'h1000, nv, nb);
        tests_run++;
        if (seen.size() != 303 || seen[300] !== 8'd44 || seen[301] !== 8'd45 || seen[302] !== 8'd46) begin
            failed++;
            $display("FAIL wrap_copy got size=%0d expected 303 ending 2c2d2e", seen.size());
        end
    endtask

    task automatic test_reset_mid_copy();
        int nv, nb;
        apply_reset();
        send_item(1'b0, 16'h0061, nv, nb);
        send_item(1'b0, 16'h0062, nv, nb);
        @(negedge clock);
        control_word_in = 1'b1;
        data_in = 16'h0F02;
        data_in_valid = 1'b1;
        model_push(1'b1, 16'h0F02);
        @(posedge clock);
        #1;
        data_in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || decompressor_busy !== 1'b0) begin
            failed++;
            $display("FAIL midcopy_abort got v=%b b=%b expected v=0 b=0", out_valid, decompressor_busy);
        end
        tests_run++;
        if (seen.size() != 4 || seen[2] !== 8'h61 || seen[3] !== 8'h62) begin
            failed++;
            $display("FAIL midcopy_partial got size=%0d expected 4 ending 6162", seen.size());
        end
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if (seen.size() != 0) begin
            failed++;
            $display("FAIL midcopy_no_more got=%0d expected=0", seen.size());
        end
        send_item(1'b0, 16'h007A, nv, nb);
        tests_run++;
        if (seen.size() != 1 || seen[0] !== 8'h7A || nv != 1) begin
            failed++;
            $display("FAIL midcopy_first_lit got size=%0d nv=%0d expected size=1 byte=7a", seen.size(), nv);
        end
    endtask

`ifdef LZRW1_DECOMP_CHECK_EN
    task automatic test_check();
        int nv, nb;
        apply_reset();
        tests_run++;
        if (copy_error !== 1'b0) begin
            failed++;
            $display("FAIL err_reset got=%b expected=0", copy_error);
        end
        send_item(1'b0, 16'h0061, nv, nb);
        send_item(1'b0, 16'h0062, nv, nb);
        send_item(1'b1, 16'h0002, nv, nb);
        tests_run++;
        if (copy_error !== 1'b0) begin
            failed++;
            $display("FAIL err_valid_off got=%b expected=0", copy_error);
        end
        apply_reset();
        send_item(1'b0, 16'h0061, nv, nb);
        send_item(1'b1, 16'h0002, nv, nb);
        tests_run++;
        if (copy_error !== 1'b1) begin
            failed++;
            $display("FAIL err_off_gt_emitted got=%b expected=1", copy_error);
        end
        apply_reset();
        send_item(1'b1, 16'h0000, nv, nb);
        tests_run++;
        if (copy_error !== 1'b1 || nv != 3) begin
            failed++;
            $display("FAIL err_off_zero got=%b nv=%0d expected=1 nv=3", copy_error, nv);
        end
        send_item(1'b0, 16'h0041, nv, nb);
        tests_run++;
        if (copy_error !== 1'b1) begin
            failed++;
            $display("FAIL err_sticky got=%b expected=1", copy_error);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        data_in = 16'h0000;
        control_word_in = 1'b0;
        data_in_valid = 1'b0;
        model_reset();
        test_reset();
        test_literals();
        test_copy();
        test_overlap();
        test_wrap();
        test_reset_mid_copy();
`ifdef LZRW1_DECOMP_CHECK_EN
        test_check();
`endif
        repeat (4) @(negedge clock);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
